// File: rtl/rr_pkt_arbiter_if.sv
// Handshake bundle between N packet requesters, the round-robin arbiter and one consumer.
// The slave modport is the arbiter's view. The master modport is the requester/consumer side.
interface rr_pkt_arbiter_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8
);
    logic [N-1:0]       req_valid;
    logic [N*WIDTH-1:0] req_data;
    logic [N-1:0]       req_last;
    logic [N-1:0]       req_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic               out_last;
    logic               out_ready;

    modport slave (
        input  req_valid, req_data, req_last, out_ready,
        output req_ready, out_valid, out_data, out_last
    );

    modport master (
        output req_valid, req_data, req_last, out_ready,
        input  req_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/rr_pkt_arbiter.sv
// Round-robin packet arbiter. It holds each grant for a whole packet and steers one N:1 stream mux.
// Optional stall watchdog: define RR_PKT_ARBITER_TIMEOUT_EN to force release after TIMEOUT idle beats.
module rr_pkt_arbiter #(
    parameter int N       = 4,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16,
    localparam int SEL_W  = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    rr_pkt_arbiter_if.slave  bus,
    output logic [SEL_W-1:0] grant_sel,
    output logic             busy,
    output logic             timeout_err
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t           state;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] winner;
    logic             any_req;
    logic             xfer;
    logic             stall_hit;

    // Scan from the requester after the last winner, wrapping modulo N.
    // The first valid requester found wins.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        winner  = '0;
        any_req = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!any_req && bus.req_valid[(int'(ptr) + k) % N]) begin
                winner  = SEL_W'((int'(ptr) + k) % N);
                any_req = 1'b1;
            end
        end
    end

    // Combinational pass-through of the granted stream, with no added per-beat latency.
    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_data  = '0;
        bus.out_last  = 1'b0;
        bus.req_ready = '0;
        if (state == GRANT) begin
            bus.out_valid            = bus.req_valid[grant_sel];
            bus.out_data             = bus.req_data[int'(grant_sel) * WIDTH +: WIDTH];
            bus.out_last             = bus.req_last[grant_sel];
            bus.req_ready[grant_sel] = bus.out_ready;
        end
    end

    assign xfer = (state == GRANT) && bus.out_valid && bus.out_ready;

`ifdef RR_PKT_ARBITER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] stall_cnt;

    // The watchdog fires on the edge that would complete the TIMEOUT-th consecutive stall cycle.
    assign stall_hit = (state == GRANT) && !xfer && (stall_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= stall_hit;
            if (state != GRANT || xfer || stall_hit)
                stall_cnt <= '0;
            else
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    assign stall_hit   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // ptr already equals the granted index, so after a forced release the next scan
    // starts past the hung requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: all state registers use non-blocking assignments, so every update sees pre-edge values.
            state     <= IDLE;
            grant_sel <= '0;
            ptr       <= SEL_W'(N - 1);
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_sel <= winner;
                        ptr       <= winner;
                        busy      <= 1'b1;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if ((xfer && bus.out_last) || stall_hit) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_pkt_arbiter.sv
// Directed bench for rr_pkt_arbiter. A cycle table covers rotation, packet hold and stalls,
// plus hand sequences for multi-beat packets, backpressure, reset and the watchdog.
module tb_rr_pkt_arbiter;
    localparam int N       = 4;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] grant_sel;
    logic       busy;
    logic       timeout_err;

    int total = 0;
    int bad   = 0;

    rr_pkt_arbiter_if #(.N(N), .WIDTH(WIDTH)) bus ();

    rr_pkt_arbiter #(.N(N), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .grant_sel   (grant_sel),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] rv;
        logic [3:0] rl;
        logic       ordy;
        logic       exp_ov;
        logic       exp_ol;
        logic [3:0] exp_rr;
        logic [1:0] exp_gs;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] rv, input logic [3:0] rl, input logic ordy,
                                input logic ov, input logic ol, input logic [3:0] rr,
                                input logic [1:0] gs, input logic bsy);
        vec_t v;
        v.rv = rv; v.rl = rl; v.ordy = ordy;
        v.exp_ov = ov; v.exp_ol = ol; v.exp_rr = rr; v.exp_gs = gs; v.exp_busy = bsy;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [3:0] rv, input logic [3:0] rl, input logic ordy);
        bus.req_valid = rv;
        bus.req_last  = rl;
        bus.out_ready = ordy;
    endtask

    task automatic reset_dut();
        set_in(4'b0000, 4'b0000, 1'b1);
        bus.req_data = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    int xfers;

    initial begin
        // Cycle table: all-valid rotation, packet hold against a competitor, single-requester repeat.
        for (int r = 0; r < 10; r++)
            vecs.push_back(mk(4'b1111, 4'b1111, 1'b1, r % 2 == 1, r % 2 == 1,
                              (r % 2 == 1) ? 4'(1 << ((r / 2) % 4)) : 4'b0000,
                              2'((r == 0) ? 0 : ((r - 1) / 2) % 4), r % 2 == 1));
        vecs.push_back(mk(4'b0000, 4'b0000, 1'b1, 0, 0, 4'b0000, 2'd0, 0));
        vecs.push_back(mk(4'b0100, 4'b0000, 1'b1, 0, 0, 4'b0000, 2'd0, 0));
        vecs.push_back(mk(4'b0110, 4'b0000, 1'b1, 1, 0, 4'b0100, 2'd2, 1));
        vecs.push_back(mk(4'b0110, 4'b0100, 1'b1, 1, 1, 4'b0100, 2'd2, 1));
        vecs.push_back(mk(4'b0010, 4'b0010, 1'b1, 0, 0, 4'b0000, 2'd2, 0));
        vecs.push_back(mk(4'b0010, 4'b0010, 1'b1, 1, 1, 4'b0010, 2'd1, 1));
        vecs.push_back(mk(4'b0001, 4'b0001, 1'b1, 0, 0, 4'b0000, 2'd1, 0));
        vecs.push_back(mk(4'b0001, 4'b0001, 1'b0, 1, 1, 4'b0000, 2'd0, 1));
        vecs.push_back(mk(4'b0001, 4'b0001, 1'b1, 1, 1, 4'b0001, 2'd0, 1));
        vecs.push_back(mk(4'b0001, 4'b0001, 1'b1, 0, 0, 4'b0000, 2'd0, 0));
        vecs.push_back(mk(4'b0001, 4'b0001, 1'b1, 1, 1, 4'b0001, 2'd0, 1));
        vecs.push_back(mk(4'b0000, 4'b0000, 1'b1, 0, 0, 4'b0000, 2'd0, 0));

        // Reset state.
        reset_dut();
        check("rst_grant_sel", grant_sel, 0);
        check("rst_busy", busy, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_timeout_err", timeout_err, 0);

        // Three-beat packet from requester 0.
        begin
            logic [7:0] beats [3];
            beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33;
            set_in(4'b0001, 4'b0000, 1'b1);
            bus.req_data[0 +: 8] = beats[0];
            #1 check("p3_idle_valid", bus.out_valid, 0);
            step();
            check("p3_grant_sel", grant_sel, 0);
            check("p3_busy", busy, 1);
            for (int k = 0; k < 3; k++) begin
                bus.req_data[0 +: 8] = beats[k];
                bus.req_last = (k == 2) ? 4'b0001 : 4'b0000;
                #1;
                check("p3_valid", bus.out_valid, 1);
                check("p3_data", bus.out_data, beats[k]);
                check("p3_last", bus.out_last, k == 2);
                check("p3_ready", bus.req_ready, 4'b0001);
                step();
            end
            set_in(4'b0000, 4'b0000, 1'b1);
            #1;
            check("p3_busy_fall", busy, 0);
            check("p3_valid_fall", bus.out_valid, 0);
        end

        // Cycle table from a fresh reset.
        reset_dut();
        bus.req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        for (int i = 0; i < vecs.size(); i++) begin
            set_in(vecs[i].rv, vecs[i].rl, vecs[i].ordy);
            #1;
            check($sformatf("vec%0d_out_valid", i), bus.out_valid, vecs[i].exp_ov);
            check($sformatf("vec%0d_req_ready", i), bus.req_ready, vecs[i].exp_rr);
            check($sformatf("vec%0d_grant_sel", i), grant_sel, vecs[i].exp_gs);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
            if (vecs[i].exp_ov) begin
                check($sformatf("vec%0d_out_last", i), bus.out_last, vecs[i].exp_ol);
                check($sformatf("vec%0d_out_data", i), bus.out_data, 8'hA0 + 8'h11 * vecs[i].exp_gs);
            end
            step();
        end

        // Backpressure: out_ready low for 5 cycles on requester 3's first beat.
        reset_dut();
        xfers = 0;
        set_in(4'b1000, 4'b0000, 1'b1);
        bus.req_data[24 +: 8] = 8'h5A;
        step();
        check("bp_grant_sel", grant_sel, 3);
        bus.out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_hold_data", bus.out_data, 8'h5A);
            check("bp_hold_ready", bus.req_ready, 4'b0000);
            if (bus.out_valid && bus.out_ready) xfers++;
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_beat0_data", bus.out_data, 8'h5A);
        check("bp_beat0_ready", bus.req_ready, 4'b1000);
        if (bus.out_valid && bus.out_ready) xfers++;
        step();
        bus.req_data[24 +: 8] = 8'h6B;
        bus.req_last = 4'b1000;
        #1;
        check("bp_beat1_data", bus.out_data, 8'h6B);
        check("bp_beat1_last", bus.out_last, 1);
        if (bus.out_valid && bus.out_ready) xfers++;
        step();
        set_in(4'b0000, 4'b0000, 1'b1);
        #1;
        check("bp_busy_fall", busy, 0);
        check("bp_beat_count", xfers, 2);

        // Reset asserted mid-packet, then every requester asks at once.
        reset_dut();
        set_in(4'b0100, 4'b0000, 1'b1);
        bus.req_data[16 +: 8] = 8'h77;
        step();
        check("mr_grant_sel", grant_sel, 2);
        set_in(4'b1111, 4'b1111, 1'b1);
        #1 check("mr_pre_valid", bus.out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mr_valid_drop", bus.out_valid, 0);
        check("mr_busy_drop", busy, 0);
        check("mr_ready_drop", bus.req_ready, 4'b0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("mr_first_grant", grant_sel, 0);
        check("mr_first_busy", busy, 1);
        #1 check("mr_first_ready", bus.req_ready, 4'b0001);

`ifdef RR_PKT_ARBITER_TIMEOUT_EN
        // Granted requester 0 goes silent; the watchdog must release it and pass the mux to requester 1.
        reset_dut();
        set_in(4'b0011, 4'b0011, 1'b1);
        step();
        check("to_grant_sel", grant_sel, 0);
        set_in(4'b0010, 4'b0011, 1'b1);
        for (int c = 1; c < TIMEOUT; c++) begin
            step();
            check($sformatf("to_quiet%0d", c), timeout_err, 0);
            check($sformatf("to_held%0d", c), busy, 1);
        end
        step();
        check("to_pulse", timeout_err, 1);
        check("to_release", busy, 0);
        set_in(4'b0011, 4'b0011, 1'b1);
        step();
        check("to_pulse_end", timeout_err, 0);
        check("to_next_grant", grant_sel, 1);
`else
        // Without the watchdog a silent grant is held indefinitely and no error is reported.
        reset_dut();
        set_in(4'b0001, 4'b0001, 1'b1);
        step();
        set_in(4'b0000, 4'b0000, 1'b1);
        for (int c = 0; c < TIMEOUT + 4; c++) begin
            step();
            check($sformatf("nt_err%0d", c), timeout_err, 0);
        end
        check("nt_still_busy", busy, 1);
        check("nt_still_grant", grant_sel, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rr_pkt_arbiter.md
Name: rr_pkt_arbiter

Overview:
- Round-robin packet arbiter that shares one N:1 data mux between N requesters.
- Each requester has a valid/ready/last stream.
- A grant is held for a whole packet, from grant through the beat with last, then released.
- Drives a select output in the encoding an N:1 mux select expects, and passes the granted stream to a single downstream consumer.

Parameters:
- N, 4, number of requesters (>=2).
- WIDTH, 8, data width per requester.
- TIMEOUT, 16, stall cycles allowed before forced release; used only with the optional feature.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  N  per-requester valid.
- req_data  input  N*WIDTH  concatenated data; requester i occupies [i*WIDTH +: WIDTH].
- req_last  input  N  per-requester end-of-packet flag.
- req_ready  output  N  per-requester ready; one-hot or zero.
- out_valid  output  1  granted stream valid.
- out_data  output  WIDTH  granted stream data.
- out_last  output  1  granted stream last.
- out_ready  input  1  downstream ready.
- grant_sel  output  $clog2(N)  index of current/last granted requester.
- busy  output  1  high while a packet grant is held.
- timeout_err  output  1  one-cycle pulse on forced release; tied 0 without the optional feature.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, grant_sel=0, last-grant pointer=N-1 (requester 0 has highest priority first), busy=0, timeout_err=0.
  - Registered outputs clear immediately on the reset edge.
  - Combinational outputs out_valid=0, req_ready=0 follow from IDLE.
- States: IDLE, GRANT.
- IDLE:
  - out_valid=0, req_ready=0.
  - If any req_valid is high, choose the first set bit scanning from (pointer+1) mod N upward with wrap.
  - Register the winner into grant_sel and pointer; go to GRANT next cycle.
  - Latency: 1 cycle from req_valid rising to the first possible out_valid.
  - No request: stay in IDLE; grant_sel holds its last value.
- GRANT:
  - busy=1.
  - out_valid=req_valid[g], out_data=req_data[g*WIDTH +: WIDTH], out_last=req_last[g].
  - req_ready[g]=out_ready; all other req_ready bits are 0.
  - Combinational pass-through, no added latency per beat.
- Beat transfer occurs when out_valid && out_ready.
- Transfer with out_last=1: next state IDLE, busy drops the next cycle.
  - There is a mandatory 1-cycle IDLE bubble between packets.
- req_valid[g] deasserting mid-packet: grant is held; out_valid=0; wait.
- Non-granted requesters are ignored until the current packet completes.
- Single requester repeatedly valid: it wins every arbitration, with 1 bubble cycle per packet.
- All N valid continuously: grants rotate 0,1,2,...,N-1,0.
- Reset mid-packet: grant is dropped immediately; after release the arbiter restarts from requester 0 priority.
- Upstream protocol rule: a requester must not drop valid once it has asserted it, until handshake. The block does not check this.
- Width rules:
  - Pointer increment wraps modulo N; N need not be a power of 2.
  - Indices >= N never appear on grant_sel.

Optional Feature:
- Macro: RR_PKT_ARBITER_TIMEOUT_EN.
- Defined:
  - A $clog2(TIMEOUT+1)-bit stall counter is active in GRANT.
  - It increments each cycle without a transfer and clears on any transfer and on entering GRANT.
  - When it reaches TIMEOUT: force next state IDLE, pulse timeout_err for 1 cycle, and advance the pointer past g so a hung requester cannot monopolise the mux.
- Undefined: no counter; timeout_err is constant 0; a grant is held indefinitely.

Test Plan:
- Reset then req_valid=4'b0001, 3-beat packet, out_ready=1:
  - grant_sel=0 one cycle after valid.
  - 3 beats appear on out_data.
  - busy falls the cycle after the last beat.
- req_valid=4'b1111 held, 1-beat packets:
  - grant_sel sequence 0,1,2,3,0.
  - Exactly one IDLE cycle between grants.
- Requester 2 mid-packet while requester 1 asserts valid:
  - req_ready[1]=0 until requester 2's last beat.
  - Requester 1 is granted next.
- out_ready=0 for 5 cycles during a packet:
  - out_data is held stable.
  - req_ready[g]=0.
  - No beat lost or duplicated.
- Assert rst_n=0 mid-packet:
  - out_valid and busy are 0 immediately.
  - After release, with all requesting, the first grant is requester 0.
- With RR_PKT_ARBITER_TIMEOUT_EN, TIMEOUT=16, granted req_valid dropped:
  - timeout_err pulses after 16 stall cycles.
  - The next grant goes to a different active requester.
